// File: rtl/controlador_funcionalidade.sv
// Arms the encoder's function code, runs it for CF*TICKS_PER_UNIT cycles on confirm, reports busy/remaining/done/abort.
// Optional build macro CF_STABLE_FILTER_EN: require STABLE_CYCLES identical nonzero CF samples before arming.
module controlador_funcionalidade #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TICKS_PER_UNIT = 10,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       CF,
    input  logic             confirma,
    input  logic             cancela,
    output logic [2:0]       funcao_ativa,
    output logic             ocupado,
    output logic [CNT_W-1:0] restante,
    output logic             concluido,
    output logic             erro
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       funcao_nx;
    logic             ocupado_nx;
    logic [CNT_W-1:0] restante_nx;
    logic             concluido_nx;
    logic             erro_nx;
    logic             qualifica_c;

    // Elaboration-time parameter legality checks
    if (STABLE_CYCLES == 0 || STABLE_CYCLES > 15) begin : g_bad_stable
        $error("STABLE_CYCLES must be in 1..15");
    end
    if (((64'(7) * 64'(TICKS_PER_UNIT)) >> CNT_W) != 64'(0)) begin : g_bad_ticks
        $error("7*TICKS_PER_UNIT does not fit in CNT_W bits");
    end

`ifdef CF_STABLE_FILTER_EN
    localparam int unsigned STB_W = 4;

    logic [STB_W-1:0] estavel_cnt;
    logic [STB_W-1:0] run_c;
    logic [2:0]       cf_prev;

    // Length of the current run of identical nonzero CF samples, including this one
    always_comb begin
        run_c = '0;
        if (CF != 3'd0) begin
            run_c = (estavel_cnt != '0 && CF == cf_prev) ? estavel_cnt + STB_W'(1) : STB_W'(1);
        end
    end

    assign qualifica_c = (state == IDLE) && (run_c == STB_W'(STABLE_CYCLES));

    // Count only accumulates while waiting in IDLE; any other state restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estavel_cnt <= '0;
            cf_prev     <= '0;
        end else begin
            estavel_cnt <= (state == IDLE && !qualifica_c) ? run_c : '0;
            cf_prev     <= CF;
        end
    end
`else
    assign qualifica_c = (state == IDLE) && (CF != 3'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            funcao_ativa <= '0;
            ocupado      <= 1'b0;
            restante     <= '0;
            concluido    <= 1'b0;
            erro         <= 1'b0;
        end else begin
            state        <= state_nx;
            funcao_ativa <= funcao_nx;
            ocupado      <= ocupado_nx;
            restante     <= restante_nx;
            concluido    <= concluido_nx;
            erro         <= erro_nx;
        end
    end

    // Next state and next registered outputs; cancela outranks confirma and completion
    always_comb begin
        state_nx     = state;
        funcao_nx    = funcao_ativa;
        ocupado_nx   = 1'b0;
        restante_nx  = '0;
        concluido_nx = 1'b0;
        erro_nx      = 1'b0;

        case (state)
            IDLE: begin
                funcao_nx = '0;
                if (qualifica_c) begin
                    state_nx  = ARMED;
                    funcao_nx = CF;
                end
            end
            ARMED: begin
                if (cancela || CF == 3'd0) begin
                    state_nx  = IDLE;
                    funcao_nx = '0;
                end else if (CF != funcao_ativa) begin
`ifdef CF_STABLE_FILTER_EN
                    state_nx  = IDLE;
                    funcao_nx = '0;
`else
                    funcao_nx = CF;
`endif
                end else if (confirma) begin
                    state_nx    = RUN;
                    ocupado_nx  = 1'b1;
                    restante_nx = CNT_W'(funcao_ativa) * CNT_W'(TICKS_PER_UNIT);
                end
            end
            RUN: begin
                if (cancela) begin
                    state_nx  = IDLE;
                    funcao_nx = '0;
                    erro_nx   = 1'b1;
                end else if (restante == CNT_W'(1)) begin
                    state_nx     = DONE;
                    concluido_nx = 1'b1;
                end else begin
                    ocupado_nx  = 1'b1;
                    restante_nx = restante - CNT_W'(1);
                end
            end
            DONE: begin
                state_nx  = IDLE;
                funcao_nx = '0;
            end
            default: begin
                state_nx  = IDLE;
                funcao_nx = '0;
            end
        endcase
    end

endmodule
